bin_to_ascii_dec: RTL and testbench

//   Iterative double-dabble converter: WIDTH-bit binary (optionally two's complement) to DIGITS

---
 rtl/bin_to_ascii_dec_if.sv | 15 +
 rtl/bin_to_ascii_dec.sv | 130 +++++++++++++
 tb/tb_bin_to_ascii_dec.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bin_to_ascii_dec_if.sv
// Handshake/result bundle between a requester and the binary-to-ASCII decimal converter.
interface bin_to_ascii_dec_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic [8*DIGITS-1:0]   ascii;
    logic [7:0]            sign_char;

    modport master (output start, value, input busy, done, ascii, sign_char);
    modport slave  (input start, value, output busy, done, ascii, sign_char);
endinterface

// File: rtl/bin_to_ascii_dec.sv
// Iterative double-dabble: WIDTH-bit (optionally signed) binary to DIGITS ASCII decimal
// characters plus sign, one ADD3/SHIFT pair per input bit, results updated atomically.
module bin_to_ascii_dec #(
    parameter int WIDTH      = 8,
    parameter int DIGITS     = 3,
    parameter bit SIGNED     = 1'b0,
    parameter bit LZ_BLANK   = 1'b0,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    bin_to_ascii_dec_if.slave  bus
);
    localparam int SW         = $clog2(WIDTH + 1);
    localparam int BW         = 4 * DIGITS;
    localparam int MIN_DIGITS = int'($ceil(real'(WIDTH) * 0.30102999566398));

    if (WIDTH < 2) begin : g_bad_width
        $error("bin_to_ascii_dec: WIDTH must be >= 2");
    end
    if (DIGITS < MIN_DIGITS) begin : g_bad_digits
        $error("bin_to_ascii_dec: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_ADD3, S_SHIFT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [SW-1:0]       step_q, step_d;
    logic                neg_q, neg_d;
    logic [8*DIGITS-1:0] ascii_q, ascii_d;
    logic [7:0]          sign_q, sign_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    mag;
    logic                neg_in;
    logic                load;
    logic [BW-1:0]       bcd_add3;
    logic [8*DIGITS-1:0] ascii_fmt;
    logic [3:0]          nib;
    logic                seen;

    // Most-negative input negates to 2^(WIDTH-1), which still fits as unsigned.
    assign neg_in = SIGNED && bus.value[WIDTH-1];
    assign mag    = neg_in ? (~bus.value + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.value;
    assign load   = ((state_q == S_IDLE) && (bus.start || CONTINUOUS)) ||
                    ((state_q == S_DONE) && CONTINUOUS);

    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        assign bcd_add3[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                               : bcd_q[4*k +: 4];
    end

    // Scan from the top digit: a digit is blank only while no nonzero digit has been seen.
    always_comb begin
        seen      = 1'b0;
        nib       = 4'd0;
        ascii_fmt = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib  = bcd_q[4*k +: 4];
            seen = seen | (nib != 4'd0);
            ascii_fmt[8*k +: 8] = (LZ_BLANK && (k != 0) && !seen) ? 8'h20 : {4'h3, nib};
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        neg_d   = neg_q;
        ascii_d = ascii_q;
        sign_d  = sign_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:  ;
            S_ADD3: begin
                bcd_d   = bcd_add3;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, shreg_d} = {bcd_q, shreg_q} << 1;
                step_d  = step_q + {{(SW-1){1'b0}}, 1'b1};
                state_d = (step_q == SW'(WIDTH - 1)) ? S_DONE : S_ADD3;
            end
            S_DONE: begin
                ascii_d = ascii_fmt;
                sign_d  = neg_q ? 8'h2D : 8'h20;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            shreg_d = mag;
            bcd_d   = '0;
            step_d  = '0;
            neg_d   = neg_in;
            state_d = S_ADD3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            neg_q   <= 1'b0;
            ascii_q <= {DIGITS{8'h30}};
            sign_q  <= 8'h20;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
            neg_q   <= neg_d;
            ascii_q <= ascii_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.ascii     = ascii_q;
    assign bus.sign_char = sign_q;
endmodule

// File: tb/tb_bin_to_ascii_dec.sv
// Directed bench: four converter configurations (plain, blanked 16-bit, signed, free-running).
module tb_bin_to_ascii_dec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bin_to_ascii_dec_if #(.WIDTH(8),  .DIGITS(3)) ia ();
    bin_to_ascii_dec_if #(.WIDTH(16), .DIGITS(5)) ib ();
    bin_to_ascii_dec_if #(.WIDTH(8),  .DIGITS(3)) ic ();
    bin_to_ascii_dec_if #(.WIDTH(8),  .DIGITS(3)) id ();

    bin_to_ascii_dec #(.WIDTH(8), .DIGITS(3)) u_a (.clk(clk), .rst(rst), .bus(ia));
    bin_to_ascii_dec #(.WIDTH(16), .DIGITS(5), .LZ_BLANK(1'b1)) u_b (.clk(clk), .rst(rst), .bus(ib));
    bin_to_ascii_dec #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_c (.clk(clk), .rst(rst), .bus(ic));
    bin_to_ascii_dec #(.WIDTH(8), .DIGITS(3), .CONTINUOUS(1'b1)) u_d (.clk(clk), .rst(rst), .bus(id));

    task automatic set_start(input int which, input logic s, input logic [15:0] v);
        case (which)
            0: begin ia.start = s; ia.value = v[7:0]; end
            1: begin ib.start = s; ib.value = v;      end
            2: begin ic.start = s; ic.value = v[7:0]; end
            default: begin id.start = s; id.value = v[7:0]; end
        endcase
    endtask

    // Drive start for exactly one accepting edge; returns at edge+1.
    task automatic pulse_start(input int which, input logic [15:0] v);
        set_start(which, 1'b1, v);
        @(posedge clk); #1;
        set_start(which, 1'b0, v);
    endtask

    // Edges until done is seen (sampled 1 after each edge); -1 if the bound expires.
    task automatic wait_done(input int which, input int max, output int cyc);
        logic d;
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            case (which)
                0: d = ia.done;
                1: d = ib.done;
                2: d = ic.done;
                default: d = id.done;
            endcase
            if (d) begin cyc = i; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", ia.busy); end
        total++; if (ia.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", ia.done); end
        total++; if (ia.ascii !== "000") begin bad++; $display("FAIL reset_ascii got=%h want=%h", ia.ascii, 24'h303030); end
        total++; if (ia.sign_char !== 8'h20) begin bad++; $display("FAIL reset_sign got=%h want=20", ia.sign_char); end
        total++; if (ib.ascii !== "00000") begin bad++; $display("FAIL reset_ascii16 got=%h want=%h", ib.ascii, 40'h3030303030); end
        total++; if (id.busy !== 1'b0) begin bad++; $display("FAIL reset_cont_busy got=%b want=0", id.busy); end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [7:0]  vals [3] = '{8'd255, 8'd0, 8'd100};
        logic [23:0] exps [3] = '{"255", "000", "100"};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            pulse_start(0, {8'd0, vals[i]});
            total++; if (ia.busy !== 1'b1) begin bad++; $display("FAIL u_busy_on[%0d] got=%b want=1", i, ia.busy); end
            wait_done(0, 40, cyc);
            total++; if (cyc != 17) begin bad++; $display("FAIL u_latency[%0d] got=%0d want=17", i, cyc); end
            total++; if (ia.ascii !== exps[i]) begin bad++; $display("FAIL u_ascii[%0d] got=%h want=%h", i, ia.ascii, exps[i]); end
            total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL u_busy_off[%0d] got=%b want=0", i, ia.busy); end
            @(posedge clk); #1;
            total++; if (ia.done !== 1'b0) begin bad++; $display("FAIL u_done_pulse[%0d] got=%b want=0", i, ia.done); end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] vals [4] = '{16'd7, 16'd0, 16'd65535, 16'd1000};
        logic [39:0] exps [4] = '{"    7", "    0", "65535", " 1000"};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            pulse_start(1, vals[i]);
            wait_done(1, 60, cyc);
            total++; if (cyc != 33) begin bad++; $display("FAIL lz_latency[%0d] got=%0d want=33", i, cyc); end
            total++; if (ib.ascii !== exps[i]) begin bad++; $display("FAIL lz_ascii[%0d] got=%h want=%h", i, ib.ascii, exps[i]); end
        end
    endtask

    task automatic test_signed();
        logic [7:0]  vals [4] = '{8'h80, 8'hFF, 8'h7F, 8'h00};
        logic [23:0] exps [4] = '{"128", "001", "127", "000"};
        logic [7:0]  sgns [4] = '{8'h2D, 8'h2D, 8'h20, 8'h20};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            pulse_start(2, {8'd0, vals[i]});
            wait_done(2, 40, cyc);
            total++; if (cyc != 17) begin bad++; $display("FAIL s_latency[%0d] got=%0d want=17", i, cyc); end
            total++; if (ic.ascii !== exps[i]) begin bad++; $display("FAIL s_ascii[%0d] got=%h want=%h", i, ic.ascii, exps[i]); end
            total++; if (ic.sign_char !== sgns[i]) begin bad++; $display("FAIL s_sign[%0d] got=%h want=%h", i, ic.sign_char, sgns[i]); end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc, cyc2;
        pulse_start(0, 16'd123);
        repeat (2) @(posedge clk);
        #1;
        pulse_start(0, 16'd45);
        wait_done(0, 40, cyc);
        total++; if (cyc != 14) begin bad++; $display("FAIL ign_latency got=%0d want=14", cyc); end
        total++; if (ia.ascii !== "123") begin bad++; $display("FAIL ign_ascii got=%h want=%h", ia.ascii, 24'h313233); end
        wait_done(0, 40, cyc2);
        total++; if (cyc2 != -1) begin bad++; $display("FAIL ign_extra_done got=%0d want=-1", cyc2); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        pulse_start(0, 16'd99);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (ia.ascii !== "000") begin bad++; $display("FAIL rm_ascii got=%h want=%h", ia.ascii, 24'h303030); end
        total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", ia.busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done(0, 40, cyc);
        total++; if (cyc != -1) begin bad++; $display("FAIL rm_no_done got=%0d want=-1", cyc); end
        pulse_start(0, 16'd7);
        wait_done(0, 40, cyc);
        total++; if (cyc != 17) begin bad++; $display("FAIL rm_restart_lat got=%0d want=17", cyc); end
        total++; if (ia.ascii !== "007") begin bad++; $display("FAIL rm_restart_ascii got=%h want=%h", ia.ascii, 24'h303037); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        set_start(0, 1'b1, 16'd10);
        @(posedge clk); #1;
        wait_done(0, 40, cyc);
        total++; if (cyc != 17) begin bad++; $display("FAIL b2b_first got=%0d want=17", cyc); end
        total++; if (ia.ascii !== "010") begin bad++; $display("FAIL b2b_ascii got=%h want=%h", ia.ascii, 24'h303130); end
        wait_done(0, 40, cyc);
        total++; if (cyc != 18) begin bad++; $display("FAIL b2b_period got=%0d want=18", cyc); end
        set_start(0, 1'b0, 16'd10);
        repeat (2) @(posedge clk);
        #1;
        total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", ia.busy); end
    endtask

    task automatic test_continuous();
        int cyc;
        wait_done(3, 40, cyc);
        total++; if (cyc == -1) begin bad++; $display("FAIL c_first_done got=%0d want=done", cyc); end
        total++; if (id.ascii !== "042") begin bad++; $display("FAIL c_ascii42 got=%h want=%h", id.ascii, 24'h303432); end
        id.value = 8'd200;
        wait_done(3, 40, cyc);
        total++; if (cyc != 17) begin bad++; $display("FAIL c_period1 got=%0d want=17", cyc); end
        total++; if (id.busy !== 1'b1) begin bad++; $display("FAIL c_busy got=%b want=1", id.busy); end
        wait_done(3, 40, cyc);
        total++; if (cyc != 17) begin bad++; $display("FAIL c_period2 got=%0d want=17", cyc); end
        total++; if (id.ascii !== "200") begin bad++; $display("FAIL c_ascii200 got=%h want=%h", id.ascii, 24'h323030); end
    endtask

    initial begin
        set_start(0, 1'b0, 16'd0);
        set_start(1, 1'b0, 16'd0);
        set_start(2, 1'b0, 16'd0);
        set_start(3, 1'b0, 16'd42);
        test_reset();
        test_unsigned();
        test_lz_blank();
        test_signed();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_continuous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
